// File: rtl/pulse_train_generator.sv
// pulse_train_generator: turns a one-cycle start request into a registered
// square wave carrying exactly `count` rising edges. Each edge is held high
// for HIGH_CYCLES and followed by LOW_CYCLES low, so a downstream edge
// detector sees one pulse per edge.
// Optional feature: define PULSE_ABORT_EN to add the abort input.
module pulse_train_generator #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned HIGH_CYCLES = 2,
  parameter int unsigned LOW_CYCLES  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
`ifdef PULSE_ABORT_EN
  input  logic             abort,
`endif
  output logic             signal,
  output logic             busy,
  output logic             done
);

  localparam int unsigned MAX_PH = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int unsigned PH_W   = $clog2(MAX_PH) + 1;
  localparam logic [PH_W-1:0] HIGH_LOAD = PH_W'(HIGH_CYCLES - 1);
  localparam logic [PH_W-1:0] LOW_LOAD  = PH_W'(LOW_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] edges;
  logic [PH_W-1:0]  phase;
  logic             kill;

`ifdef PULSE_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  // Train sequencer: state, edge/phase counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      edges  <= '0;
      phase  <= '0;
      signal <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (kill && state != IDLE) begin
        // Abort drops the train silently: no done pulse.
        state  <= IDLE;
        edges  <= '0;
        phase  <= '0;
        signal <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            signal <= 1'b0;
            busy   <= 1'b0;
            if (start && !kill) begin
              if (count != '0) begin
                state  <= HIGH;
                edges  <= count;
                phase  <= HIGH_LOAD;
                signal <= 1'b1;
                busy   <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end
          end
          HIGH: begin
            if (phase == '0) begin
              // Edge counter is nonzero here, so this decrement never wraps.
              state  <= LOW;
              edges  <= edges - CNT_W'(1);
              phase  <= LOW_LOAD;
              signal <= 1'b0;
            end else begin
              phase <= phase - PH_W'(1);
            end
          end
          LOW: begin
            if (phase == '0) begin
              if (edges != '0) begin
                state  <= HIGH;
                phase  <= HIGH_LOAD;
                signal <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              phase <= phase - PH_W'(1);
            end
          end
          default: begin
            state  <= IDLE;
            edges  <= '0;
            phase  <= '0;
            signal <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed bench for pulse_train_generator with HIGH_CYCLES=2, LOW_CYCLES=3.
// Cycle T+k is the value observed on the falling edge before rising edge T+k,
// where T is the edge that samples start. Abort cases need PULSE_ABORT_EN.
module tb_pulse_train_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] count;
  logic       abort;
  logic       signal;
  logic       busy;
  logic       done;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  pulse_train_generator #(
    .CNT_W(8),
    .HIGH_CYCLES(2),
    .LOW_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .count(count),
`ifdef PULSE_ABORT_EN
    .abort(abort),
`endif
    .signal(signal),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Launches a train and checks signal/busy/done for cycles T+1..T+cycles.
  // Bit k-1 of each mask is the expectation (or the drive) for cycle T+k;
  // drives are applied after that cycle's checks, i.e. sampled at edge T+k.
  task automatic run_train(input string tag, input logic [7:0] n, input int unsigned cycles,
                           input logic [31:0] sigm, input logic [31:0] busym,
                           input logic [31:0] donem, input logic [31:0] pokem,
                           input logic [31:0] rstm, input logic [31:0] abtm,
                           input logic [7:0] poke_cnt, input logic abort_at_start,
                           input int unsigned exp_edges);
    logic prev;
    int unsigned rises;
    prev  = 1'b0;
    rises = 0;
    @(negedge clk);
    start = 1'b1;
    count = n;
    abort = abort_at_start;
    for (int unsigned k = 1; k <= cycles; k++) begin
      @(negedge clk);
      check($sformatf("%s_sig_T%0d", tag, k), 32'(signal), 32'(sigm[k-1]));
      check($sformatf("%s_busy_T%0d", tag, k), 32'(busy), 32'(busym[k-1]));
      check($sformatf("%s_done_T%0d", tag, k), 32'(done), 32'(donem[k-1]));
      if (signal && !prev) rises++;
      prev  = signal;
      start = pokem[k-1];
      count = pokem[k-1] ? poke_cnt : 8'd0;
      rst   = rstm[k-1];
      abort = abtm[k-1];
    end
    check($sformatf("%s_edges", tag), rises, exp_edges);
    start = 1'b0;
    rst   = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int unsigned done_k;
    int unsigned rises;
    logic prev;

    rst   = 1'b1;
    start = 1'b0;
    count = 8'd0;
    abort = 1'b0;

    // Reset held three cycles: all outputs low throughout.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rst_sig_%0d", k), 32'(signal), 32'd0);
      check($sformatf("rst_busy_%0d", k), 32'(busy), 32'd0);
      check($sformatf("rst_done_%0d", k), 32'(done), 32'd0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // count=3: high T+1..2, T+6..7, T+11..12; busy T+1..15; done T+16.
    run_train("n3", 8'd3, 17, 32'h0000_0C63, 32'h0000_7FFF, 32'h0000_8000,
              32'h0, 32'h0, 32'h0, 8'd0, 1'b0, 3);

    // count=0: done at T+1 only, no edge, never busy.
    run_train("n0", 8'd0, 3, 32'h0, 32'h0, 32'h1,
              32'h0, 32'h0, 32'h0, 8'd0, 1'b0, 0);

    // Start at T+4 ignored; start in done cycle T+16 launches count=1 at T+17.
    run_train("b2b", 8'd3, 23, 32'h0003_0C63, 32'h001F_7FFF, 32'h0020_8000,
              32'h0000_8008, 32'h0, 32'h0, 8'd1, 1'b0, 4);

    // Reset sampled at T+7 and T+8: outputs low from T+8, no done.
    run_train("rstmid", 8'd3, 20, 32'h0000_0063, 32'h0000_007F, 32'h0,
              32'h0, 32'h0000_00C0, 32'h0, 8'd0, 1'b0, 2);

`ifdef PULSE_ABORT_EN
    // Abort sampled at T+6: low and idle from T+7, two edges, no done.
    run_train("abort", 8'd3, 18, 32'h0000_0023, 32'h0000_003F, 32'h0,
              32'h0, 32'h0, 32'h0000_0020, 8'd0, 1'b0, 2);
    // Abort together with start in IDLE: start dropped.
    run_train("abst", 8'd3, 6, 32'h0, 32'h0, 32'h0,
              32'h0, 32'h0, 32'h0, 8'd0, 1'b1, 0);
    // Abort in IDLE alone: no effect on the following train.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    run_train("abidle", 8'd1, 6, 32'h0000_0003, 32'h0000_001F, 32'h0000_0020,
              32'h0, 32'h0, 32'h0, 8'd0, 1'b0, 1);
`endif

    // Full-scale count=255: done at T+1+255*5 = T+1276, 255 edges.
    @(negedge clk);
    start  = 1'b1;
    count  = 8'd255;
    done_k = 0;
    rises  = 0;
    prev   = 1'b0;
    for (int unsigned k = 1; k <= 1400; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (signal && !prev) rises++;
      prev = signal;
      if (done) begin
        done_k = k;
        break;
      end
    end
    check("max_done_cycle", done_k, 32'd1276);
    check("max_edges", rises, 32'd255);
    check("max_busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("max_done_one_cycle", 32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
